// File: rtl/bt_cmd_ctrl.sv
// Bluetooth command controller: frames UART bytes into HEADER/OPCODE/OPERAND[/CHECK]
// commands and applies them to an LED register. Define BT_CHECKSUM_EN for the XOR check byte.
module bt_cmd_ctrl #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 52080,
  parameter logic [7:0]  LED_RESET      = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_frame_err,
  output logic [7:0] leds,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic [7:0] err_count
);

  localparam int unsigned     CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

`ifdef BT_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_OPCODE, ST_OPERAND, ST_CHECK, ST_EXEC} state_e;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_OPCODE, ST_OPERAND, ST_EXEC} state_e;
`endif

  state_e        state_q, state_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [7:0]    operand_q, operand_d;
  logic [7:0]    leds_q, leds_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          fail;
  logic          hdr_ok;

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    operand_d   = operand_q;
    leds_d      = leds_q;
    err_count_d = err_count_q;
    cnt_d       = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    fail        = 1'b0;
    // A frame error in the same cycle drops the byte, even in IDLE.
    hdr_ok      = rx_valid && !rx_frame_err && (rx_data == HEADER);

    case (state_q)
      ST_IDLE: begin
        if (hdr_ok) state_d = ST_OPCODE;
      end
      ST_EXEC: begin
        // A byte arriving during EXEC is handled as if already in IDLE.
        state_d = hdr_ok ? ST_OPCODE : ST_IDLE;
        if (rx_frame_err) begin
          fail = 1'b1;
        end else begin
          case (opcode_q)
            8'h01:   leds_d = operand_q;
            8'h02:   leds_d = leds_q | operand_q;
            8'h03:   leds_d = leds_q & ~operand_q;
            8'h04:   leds_d = leds_q ^ operand_q;
            default: fail = 1'b1;
          endcase
        end
        done_d = !fail;
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (rx_frame_err) begin
          fail    = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          cnt_d = '0;
          case (state_q)
            ST_OPCODE: begin
              opcode_d = rx_data;
              state_d  = ST_OPERAND;
            end
            ST_OPERAND: begin
              operand_d = rx_data;
`ifdef BT_CHECKSUM_EN
              state_d   = ST_CHECK;
`else
              state_d   = ST_EXEC;
`endif
            end
`ifdef BT_CHECKSUM_EN
            ST_CHECK: begin
              if (rx_data == (opcode_q ^ operand_q)) begin
                state_d = ST_EXEC;
              end else begin
                fail    = 1'b1;
                state_d = ST_IDLE;
              end
            end
`endif
            default: ;
          endcase
        end else if (cnt_q == CNT_LAST) begin
          // Fires on the TIMEOUT_CYCLES-th idle edge after the last accepted byte.
          fail    = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase

    if (fail) begin
      err_d = 1'b1;
      cnt_d = '0;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      operand_q   <= '0;
      leds_q      <= LED_RESET;
      err_count_q <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      operand_q   <= operand_d;
      leds_q      <= leds_d;
      err_count_q <= err_count_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign leds      = leds_q;
  assign busy      = busy_q;
  assign cmd_done  = done_q;
  assign cmd_err   = err_q;
  assign err_count = err_count_q;

endmodule
